dmac_ctrl_arbiter: RTL and testbench
====================================

// Module: dmac_ctrl_arbiter
// PURPOSE
// - Shares the single DMA controller configuration target among NB_REQ initiators (cluster cores, FC, accelerators).
// - Round-robin request arbitration and in-order response routing back to the issuing initiator.
// - Optional command lock keeps a multi-word DMA command sequence from one initiator atomic.
// - Sits between the peripheral interconnect initiator ports and the DMA controller ctrl target port.
// PARAMETERS
// - NB_REQ       4   number of initiator ports (>=2)
// - ADDR_WIDTH   32  ctrl address width
// - DATA_WIDTH   32  ctrl data width; BE_WIDTH = DATA_WIDTH/8
// - ID_WIDTH     1   transaction id width, passed through unchanged
// - OUTSTANDING  4   max granted-but-unanswered transactions (power of 2, >=2)
// - CMD_OFFSET   0   word offset (add[7:2]) of the DMA command register
// - LOCK_BEATS   3   consecutive CMD_OFFSET writes forming one command (lock only)
// - LOCK_TMO     64  idle cycles after which a held lock is force-released (lock only)
// PORTS
// - clk_i       in   1                   clock
// - rst_i       in   1                   synchronous reset, active-high
// - s_req_i     in   NB_REQ              initiator request
// - s_add_i     in   NB_REQ*ADDR_WIDTH   initiator address
// - s_wen_i     in   NB_REQ              1 = read, 0 = write
// - s_wdata_i   in   NB_REQ*DATA_WIDTH   write data
// - s_be_i      in   NB_REQ*BE_WIDTH     byte enables
// - s_id_i      in   NB_REQ*ID_WIDTH     transaction id
// - s_gnt_o     out  NB_REQ              grant, one-hot or zero
// - s_r_valid_o out  NB_REQ              response valid, one-hot or zero
// - s_r_rdata_o out  DATA_WIDTH          response data, shared by all initiators
// - s_r_opc_o   out  1                   response error flag, shared
// - s_r_id_o    out  ID_WIDTH            response id, shared
// - m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o  out  1/ADDR/1/DATA/BE/ID  to DMA ctrl target
// - m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i, m_r_id_i in  1/1/DATA/1/ID  from DMA ctrl target
// - err_o       out  1                   sticky: m_r_valid_i seen with no outstanding transaction
// BEHAVIOUR
// - Reset: all s_gnt_o/s_r_valid_o = 0, m_req_o = 0, RR pointer = 0, FIFO empty, lock clear, err_o = 0.
// - Eligible = s_req_i masked by lock owner (if locked) and by FIFO not full; FIFO full => m_req_o = 0, even if a pop occurs that cycle.
// - Winner = first eligible index at or after RR pointer (wrapping); m_* mux winner fields combinationally, m_req_o = |eligible.
// - s_gnt_o[winner] = m_gnt_i & m_req_o (zero-latency path); other grants 0.
// - On handshake: push winner index into response FIFO; RR pointer <= (winner+1) mod NB_REQ. No handshake => pointer holds.
// - Winner is recomputed every cycle; a requester may drop req without grant (no hold requirement).
// - On m_r_valid_i: pop FIFO head h; s_r_valid_o[h] = 1 same cycle; rdata/opc/id passed through combinationally.
// - Push and pop in the same cycle allowed when not full; count unchanged.
// - m_r_valid_i with FIFO empty: response dropped, err_o <= 1 (cleared only by reset).
// - Reset mid-transaction: FIFO flushed; late responses after reset set err_o.
// CONFIGURATION
// - Macro DMAC_ARB_CMD_LOCK_EN.
// - Defined: handshake of a write to CMD_OFFSET with lock clear sets lock, owner = winner, beat count = 1.
// - Each further owner write to CMD_OFFSET increments count; reaching LOCK_BEATS clears lock.
// - Owner reads/other-offset writes pass without counting; non-owners are masked while locked.
// - Idle counter resets on any owner handshake, increments otherwise; reaching LOCK_TMO clears lock.
// - Not defined: no lock state, no timeout counter, pure round-robin; LOCK_* parameters ignored.
// STRUCTURE
// - Package dmac_arb_pkg: CMD_OFFSET default, idx_t = logic [$clog2(NB_REQ)-1:0], lock state struct {locked, owner, beats, idle}.
// - Sub-module dmac_arb_resp_fifo: OUTSTANDING-deep idx_t FIFO, push/pop/full/empty, sync active-high reset.
// - Top: RR pointer, priority encoder, lock FSM (IDLE/LOCKED), muxes.
// TESTING
// - Reqs 0,1,2,3 held high, m_gnt_i=1, r_valid one cycle later -> grants 0,1,2,3,0 in order; each response routed to granting port.
// - Only req 2 high repeatedly -> granted every cycle; pointer advances to 3 each time, no starvation of later arrivals.
// - m_gnt_i=1, m_r_valid_i=0 for 5 cycles, OUTSTANDING=4 -> 4 grants, then m_req_o=0 until a response pops.
// - Responses with m_r_opc_i=1, m_r_id_i=1 -> s_r_opc_o=1, s_r_id_o=1, s_r_valid_o one-hot on FIFO head.
// - m_r_valid_i pulse after reset with nothing outstanding -> no s_r_valid_o, err_o=1 held until rst_i.
// - Lock: port1 writes CMD_OFFSET, port0 requests -> port0 blocked until port1's 3rd CMD write; port1 idle 64 cycles -> lock released, port0 granted.

Source files
------------

// File: rtl/dmac_arb_pkg.sv
// Shared types and defaults for the DMA controller ctrl-port arbiter.
// The idx_t and lock_state_t types are sized for the default port count.
package dmac_arb_pkg;

  localparam int ARB_NB_REQ      = 4;
  localparam int CMD_OFFSET_DEF  = 0;
  localparam int LOCK_BEATS_DEF  = 3;
  localparam int LOCK_TMO_DEF    = 64;

  typedef logic [$clog2(ARB_NB_REQ)-1:0] idx_t;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_fsm_e;

  typedef struct packed {
    logic        locked;
    idx_t        owner;
    logic [7:0]  beats;
    logic [15:0] idle;
  } lock_state_t;

endpackage

// File: rtl/dmac_arb_resp_fifo.sv
// In-order FIFO of granted initiator indices, one entry per outstanding
// transaction. Head is the initiator the next response belongs to.
module dmac_arb_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/dmac_ctrl_arbiter.sv
// Round-robin arbiter sharing the DMA controller ctrl target among NB_REQ
// initiators, with in-order response routing back to the issuer.
// Optional command lock enabled by defining DMAC_ARB_CMD_LOCK_EN.
module dmac_ctrl_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int NB_REQ      = ARB_NB_REQ,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 1,
  parameter int OUTSTANDING = 4,
  parameter int CMD_OFFSET  = CMD_OFFSET_DEF,
  parameter int LOCK_BEATS  = LOCK_BEATS_DEF,
  parameter int LOCK_TMO    = LOCK_TMO_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_REQ-1:0]              s_req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]   s_add_i,
  input  logic [NB_REQ-1:0]              s_wen_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [NB_REQ*DATA_WIDTH/8-1:0] s_be_i,
  input  logic [NB_REQ*ID_WIDTH-1:0]     s_id_i,
  output logic [NB_REQ-1:0]              s_gnt_o,
  output logic [NB_REQ-1:0]              s_r_valid_o,
  output logic [DATA_WIDTH-1:0]          s_r_rdata_o,
  output logic                           s_r_opc_o,
  output logic [ID_WIDTH-1:0]            s_r_id_o,
  output logic                           m_req_o,
  output logic [ADDR_WIDTH-1:0]          m_add_o,
  output logic                           m_wen_o,
  output logic [DATA_WIDTH-1:0]          m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        m_be_o,
  output logic [ID_WIDTH-1:0]            m_id_o,
  input  logic                           m_gnt_i,
  input  logic                           m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
  input  logic                           m_r_opc_i,
  input  logic [ID_WIDTH-1:0]            m_r_id_i,
  output logic                           err_o
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int BE_W  = DATA_WIDTH / 8;

  if (NB_REQ < 2 || OUTSTANDING < 2 || LOCK_BEATS < 1 || LOCK_TMO < 1 ||
      CMD_OFFSET < 0 || CMD_OFFSET > 63) begin : g_cfg_err
    $error("dmac_ctrl_arbiter: unsupported parameter combination");
  end

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic [NB_REQ-1:0] lock_mask;
  logic [NB_REQ-1:0] eligible;
  logic              handshake;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [IDX_W-1:0]  fifo_head;

  // A full FIFO blocks every request, even in a cycle where a response pops.
  assign eligible  = s_req_i & lock_mask & {NB_REQ{~fifo_full}};
  assign m_req_o   = |eligible;
  assign handshake = m_req_o & m_gnt_i;
  assign fifo_pop  = m_r_valid_i & ~fifo_empty;

  // Pick the first eligible initiator at or after the round-robin pointer.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < NB_REQ; k++) begin
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == IDX_W'(NB_REQ-1)) ? '0 : cand + IDX_W'(1);
    end
  end

  assign m_add_o   = s_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_wen_o   = s_wen_i[winner];
  assign m_wdata_o = s_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign m_be_o    = s_be_i[int'(winner)*BE_W +: BE_W];
  assign m_id_o    = s_id_i[int'(winner)*ID_WIDTH +: ID_WIDTH];

  // Grant and response-valid decode: at most one bit of each is set.
  always_comb begin
    s_gnt_o             = '0;
    s_gnt_o[winner]     = handshake;
    s_r_valid_o         = '0;
    s_r_valid_o[fifo_head] = fifo_pop;
  end

  assign s_r_rdata_o = m_r_rdata_i;
  assign s_r_opc_o   = m_r_opc_i;
  assign s_r_id_o    = m_r_id_i;

  // Pointer moves past the winner only when the target accepts the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (winner == IDX_W'(NB_REQ-1)) ? '0 : winner + IDX_W'(1);
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (m_r_valid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  dmac_arb_resp_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef DMAC_ARB_CMD_LOCK_EN
  lock_fsm_e   state_q, state_d;
  lock_state_t lock_q, lock_d;
  logic        win_cmd_write;

  assign win_cmd_write = ~m_wen_o & (m_add_o[7:2] == 6'(CMD_OFFSET));

  // Lock state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LK_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Lock FSM: first command write takes the lock, the last beat or an idle timeout frees it.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      LK_IDLE: begin
        if (handshake && win_cmd_write && LOCK_BEATS > 1) begin
          state_d      = LK_LOCKED;
          lock_d.owner = idx_t'(winner);
          lock_d.beats = 8'd1;
          lock_d.idle  = '0;
        end
      end
      LK_LOCKED: begin
        if (handshake && idx_t'(winner) == lock_q.owner) begin
          lock_d.idle = '0;
          if (win_cmd_write) begin
            lock_d.beats = lock_q.beats + 8'd1;
            if (lock_d.beats == 8'(LOCK_BEATS)) state_d = LK_IDLE;
          end
        end else begin
          lock_d.idle = lock_q.idle + 16'd1;
          if (lock_d.idle == 16'(LOCK_TMO)) state_d = LK_IDLE;
        end
      end
      default: state_d = LK_IDLE;
    endcase
    lock_d.locked = (state_d == LK_LOCKED);
  end

  // While locked only the owner may compete.
  always_comb begin
    lock_mask = '1;
    if (lock_q.locked) begin
      lock_mask                      = '0;
      lock_mask[IDX_W'(lock_q.owner)] = 1'b1;
    end
  end
`else
  assign lock_mask = '1;
`endif

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Self-checking bench for dmac_ctrl_arbiter: vector table for arbitration,
// routing and FIFO-full behaviour, plus sequences for error and lock cases.
module tb_dmac_ctrl_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NB-1:0]    s_req_i;
  logic [NB*AW-1:0] s_add_i;
  logic [NB-1:0]    s_wen_i;
  logic [NB*DW-1:0] s_wdata_i;
  logic [NB*BW-1:0] s_be_i;
  logic [NB*IW-1:0] s_id_i;
  logic [NB-1:0]    s_gnt_o;
  logic [NB-1:0]    s_r_valid_o;
  logic [DW-1:0]    s_r_rdata_o;
  logic             s_r_opc_o;
  logic [IW-1:0]    s_r_id_o;
  logic             m_req_o;
  logic [AW-1:0]    m_add_o;
  logic             m_wen_o;
  logic [DW-1:0]    m_wdata_o;
  logic [BW-1:0]    m_be_o;
  logic [IW-1:0]    m_id_o;
  logic             m_gnt_i;
  logic             m_r_valid_i;
  logic [DW-1:0]    m_r_rdata_i;
  logic             m_r_opc_i;
  logic [IW-1:0]    m_r_id_i;
  logic             err_o;

  always #5 clk = ~clk;

  dmac_ctrl_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
    .s_wdata_i(s_wdata_i), .s_be_i(s_be_i), .s_id_i(s_id_i),
    .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o),
    .s_r_opc_o(s_r_opc_o), .s_r_id_o(s_r_id_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_id_o(m_id_o),
    .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i),
    .m_r_opc_i(m_r_opc_i), .m_r_id_i(m_r_id_i),
    .err_o(err_o)
  );

  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic       opc;
    logic       id;
    logic [3:0] exp_gnt;
    logic [3:0] exp_rv;
    logic       exp_mreq;
    logic       exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] addr_tab  [NB];
  logic [31:0] wdata_tab [NB];
  logic        wen_tab   [NB];
  vec_t        vecs      [25];

  function automatic vec_t mk(logic [3:0] req, logic gnt, logic rv, logic opc, logic id,
                              logic [3:0] eg, logic [3:0] erv, logic em, logic ee);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.opc = opc; v.id = id;
    v.exp_gnt = eg; v.exp_rv = erv; v.exp_mreq = em; v.exp_err = ee;
    return v;
  endfunction

  function automatic int oh2idx(logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NB; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic load_ports();
    for (int i = 0; i < NB; i++) begin
      s_add_i[i*AW +: AW]   = addr_tab[i];
      s_wdata_i[i*DW +: DW] = wdata_tab[i];
      s_wen_i[i]            = wen_tab[i];
      s_be_i[i*BW +: BW]    = 4'hF;
      s_id_i[i]             = 1'(i);
    end
  endtask

  task automatic default_ports();
    for (int i = 0; i < NB; i++) begin
      addr_tab[i]  = 32'hA000_0010 | (32'(i) << 12);
      wdata_tab[i] = 32'h5500_0000 + 32'(i);
      wen_tab[i]   = 1'b1;
    end
    load_ports();
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    s_req_i     = v.req;
    m_gnt_i     = v.gnt;
    m_r_valid_i = v.rv;
    m_r_opc_i   = v.opc;
    m_r_id_i    = v.id;
    m_r_rdata_i = 32'hD000_0000 + 32'(n);
  endtask

  task automatic checkOutput(input vec_t v, input int n, input string tag);
    int w;
    compare($sformatf("%s gnt", tag), 32'(s_gnt_o), 32'(v.exp_gnt));
    compare($sformatf("%s r_valid", tag), 32'(s_r_valid_o), 32'(v.exp_rv));
    compare($sformatf("%s m_req", tag), 32'(m_req_o), 32'(v.exp_mreq));
    compare($sformatf("%s err", tag), 32'(err_o), 32'(v.exp_err));
    if (v.exp_rv != 4'b0000) begin
      compare($sformatf("%s rdata", tag), s_r_rdata_o, 32'hD000_0000 + 32'(n));
      compare($sformatf("%s opc", tag), 32'(s_r_opc_o), 32'(v.opc));
      compare($sformatf("%s r_id", tag), 32'(s_r_id_o), 32'(v.id));
    end
    if (v.exp_gnt != 4'b0000) begin
      w = oh2idx(v.exp_gnt);
      compare($sformatf("%s m_add", tag), m_add_o, addr_tab[w]);
      compare($sformatf("%s m_wdata", tag), m_wdata_o, wdata_tab[w]);
      compare($sformatf("%s m_wen", tag), 32'(m_wen_o), 32'(wen_tab[w]));
      compare($sformatf("%s m_id", tag), 32'(m_id_o), 32'(w & 1));
      compare($sformatf("%s m_be", tag), 32'(m_be_o), 32'hF);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n, input string tag);
    applyStimulus(v, n);
    @(negedge clk);
    checkOutput(v, n, tag);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    applyStimulus(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(4'b1111, 1, 0, 0, 0, 4'b0001, 4'b0000, 1, 0);
    vecs[1]  = mk(4'b1111, 1, 1, 0, 1, 4'b0010, 4'b0001, 1, 0);
    vecs[2]  = mk(4'b1111, 1, 1, 1, 0, 4'b0100, 4'b0010, 1, 0);
    vecs[3]  = mk(4'b1111, 1, 1, 0, 0, 4'b1000, 4'b0100, 1, 0);
    vecs[4]  = mk(4'b1111, 1, 1, 0, 1, 4'b0001, 4'b1000, 1, 0);
    vecs[5]  = mk(4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0);
    vecs[6]  = mk(4'b0100, 1, 0, 0, 0, 4'b0100, 4'b0000, 1, 0);
    vecs[7]  = mk(4'b0100, 1, 1, 0, 0, 4'b0100, 4'b0100, 1, 0);
    vecs[8]  = mk(4'b0101, 1, 1, 0, 0, 4'b0001, 4'b0100, 1, 0);
    vecs[9]  = mk(4'b0101, 1, 1, 0, 0, 4'b0100, 4'b0001, 1, 0);
    vecs[10] = mk(4'b0000, 1, 1, 1, 1, 4'b0000, 4'b0100, 0, 0);
    vecs[11] = mk(4'b1111, 1, 0, 0, 0, 4'b1000, 4'b0000, 1, 0);
    vecs[12] = mk(4'b1111, 1, 0, 0, 0, 4'b0001, 4'b0000, 1, 0);
    vecs[13] = mk(4'b1111, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0);
    vecs[14] = mk(4'b1111, 1, 0, 0, 0, 4'b0100, 4'b0000, 1, 0);
    vecs[15] = mk(4'b1111, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    vecs[16] = mk(4'b1111, 1, 1, 1, 0, 4'b0000, 4'b1000, 0, 0);
    vecs[17] = mk(4'b1111, 1, 0, 0, 0, 4'b1000, 4'b0000, 1, 0);
    vecs[18] = mk(4'b0000, 0, 1, 1, 1, 4'b0000, 4'b0001, 0, 0);
    vecs[19] = mk(4'b0000, 0, 1, 0, 1, 4'b0000, 4'b0010, 0, 0);
    vecs[20] = mk(4'b0000, 0, 1, 1, 0, 4'b0000, 4'b0100, 0, 0);
    vecs[21] = mk(4'b0000, 0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0);
    vecs[22] = mk(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0);
    vecs[23] = mk(4'b0010, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0);
    vecs[24] = mk(4'b0000, 0, 1, 0, 1, 4'b0000, 4'b0010, 0, 0);

    default_ports();
    do_reset();
    run_vec(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0), 0, "reset");

    for (int i = 0; i < 25; i++) run_vec(vecs[i], i, $sformatf("vec%0d", i));

    // Stray response with nothing outstanding, then reset with one in flight.
    run_vec(mk(4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0), 100, "stray");
    run_vec(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1), 101, "err_set");
    run_vec(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1), 102, "err_hold");
    run_vec(mk(4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0000, 1, 1), 103, "err_push");
    rst_i = 1'b1;
    run_vec(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1), 104, "err_in_rst");
    rst_i = 1'b0;
    run_vec(mk(4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0), 105, "late_resp");
    run_vec(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1), 106, "late_err");

    // Port 1 issues writes to the command register; port 0 competes.
    do_reset();
    addr_tab[1] = 32'hA000_1000;
    wen_tab[1]  = 1'b0;
    load_ports();
    run_vec(mk(4'b0010, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0), 200, "cmd1");
`ifdef DMAC_ARB_CMD_LOCK_EN
    run_vec(mk(4'b0011, 1, 1, 0, 0, 4'b0010, 4'b0010, 1, 0), 201, "lock_cmd2");
    run_vec(mk(4'b0001, 1, 1, 0, 0, 4'b0000, 4'b0010, 0, 0), 202, "lock_block");
    run_vec(mk(4'b0011, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0), 203, "lock_cmd3");
    run_vec(mk(4'b0001, 1, 1, 0, 0, 4'b0001, 4'b0010, 1, 0), 204, "lock_freed");
    run_vec(mk(4'b0010, 1, 1, 0, 0, 4'b0010, 4'b0001, 1, 0), 205, "tmo_take");
    for (int k = 1; k <= 64; k++) begin
      run_vec(mk(4'b0001, 1, (k == 1), 0, 0, 4'b0000, (k == 1) ? 4'b0010 : 4'b0000, 0, 0),
              300 + k, $sformatf("tmo_wait%0d", k));
    end
    run_vec(mk(4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0000, 1, 0), 400, "tmo_release");
`else
    run_vec(mk(4'b0011, 1, 1, 0, 0, 4'b0001, 4'b0010, 1, 0), 201, "nolock_rr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
